// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32I memory-access pipeline stage.
// Takes the registered execute result and runs loads and stores over a
// req/resp data-memory handshake. Upstream is stalled (in_ready low) while a
// request is outstanding. Non-memory results pass through with one cycle of
// latency. Only WIDTH = 32 is supported.
// Optional feature macro: MEM_MISALIGN_TRAP_EN. When it is defined, a
// misaligned half or word access is not issued and is flagged on out_misalign.
module mem_access_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_addr,
  input  logic [WIDTH-1:0] in_wdata,
  input  logic [2:0]       in_funct3,
  input  logic [4:0]       in_rd,
  input  logic             in_mem_read,
  input  logic             in_mem_write,
  input  logic             in_load_regfile,
  output logic             dmem_read,
  output logic             dmem_write,
  output logic [WIDTH-1:0] dmem_addr,
  output logic [3:0]       dmem_wmask,
  output logic [WIDTH-1:0] dmem_wdata,
  input  logic [WIDTH-1:0] dmem_rdata,
  input  logic             dmem_resp,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [4:0]       out_rd,
  output logic             out_load_regfile,
  output logic             out_misalign
);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  // Undefined funct3 encodings fall through to a word access.
  function automatic size_t size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: size_of = SZ_B;
      3'b001, 3'b101: size_of = SZ_H;
      default:        size_of = SZ_W;
    endcase
  endfunction

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [2:0]       r_funct3;
  logic [4:0]       r_rd;
  logic             r_is_load;
  logic             r_is_store;
  logic             r_load_regfile;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [4:0]       r_out_rd;
  logic             r_out_load_regfile;
  logic             r_out_misalign;

  logic             w_accept;
  logic             w_in_mem;
  logic             w_in_misalign;
  logic             w_issue;
  logic             w_access;
  logic             w_done;
  size_t            w_req_size;
  logic [3:0]       w_wmask;
  logic [WIDTH-1:0] w_wdata;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [WIDTH-1:0] w_load_data;

  assign in_ready = (r_state == S_IDLE);
  assign w_accept = in_valid && in_ready;
  assign w_in_mem = in_mem_read || in_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
  size_t w_in_size;
  assign w_in_size     = size_of(in_funct3);
  assign w_in_misalign = w_in_mem &&
                         (((w_in_size == SZ_H) && in_addr[0]) ||
                          ((w_in_size == SZ_W) && (in_addr[1:0] != 2'b00)));
`else
  // Misaligned accesses are issued anyway; the lane logic below realigns them.
  assign w_in_misalign = 1'b0;
`endif

  assign w_issue  = w_accept && w_in_mem && !w_in_misalign;
  assign w_access = (r_state == S_ACCESS);
  assign w_done   = w_access && dmem_resp;

  // State register; async reset abandons any outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; dmem_resp outside ACCESS is ignored.
  always_comb begin
    // NOTE: default assigned first so no path leaves the signal unassigned,
    // which would otherwise infer a latch.
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_issue) w_state_next = S_ACCESS;
      S_ACCESS: if (dmem_resp) w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Capture the request so the memory interface stays stable during ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr         <= '0;
      r_wdata        <= '0;
      r_funct3       <= '0;
      r_rd           <= '0;
      r_is_load      <= 1'b0;
      r_is_store     <= 1'b0;
      r_load_regfile <= 1'b0;
    end else if (w_issue) begin
      r_addr         <= in_addr;
      r_wdata        <= in_wdata;
      r_funct3       <= in_funct3;
      r_rd           <= in_rd;
      r_is_load      <= in_mem_read && !in_mem_write;  // both set => store
      r_is_store     <= in_mem_write;
      r_load_regfile <= in_load_regfile;
    end
  end

  assign w_req_size = size_of(r_funct3);

  // Store byte enables and lane-replicated data from the captured request.
  always_comb begin
    w_wmask = 4'b1111;
    w_wdata = r_wdata;
    case (w_req_size)
      SZ_B: begin
        w_wmask = 4'b0001 << r_addr[1:0];
        w_wdata = {4{r_wdata[7:0]}};
      end
      SZ_H: begin
        w_wmask = 4'b0011 << {r_addr[1], 1'b0};
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
    if (!r_is_store) w_wmask = 4'b0000;
  end

  assign dmem_read  = w_access && r_is_load;
  assign dmem_write = w_access && r_is_store;
  assign dmem_addr  = {r_addr[WIDTH-1:2], 2'b00};
  assign dmem_wmask = w_wmask;
  assign dmem_wdata = w_wdata;

  // Pick the addressed lane out of the read word and extend it.
  always_comb begin
    case (r_addr[1:0])
      2'b00:   w_byte = dmem_rdata[7:0];
      2'b01:   w_byte = dmem_rdata[15:8];
      2'b10:   w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (w_req_size)
      SZ_B:    w_load_data = {{24{w_byte[7] & ~r_funct3[2]}}, w_byte};
      SZ_H:    w_load_data = {{16{w_half[15] & ~r_funct3[2]}}, w_half};
      default: w_load_data = dmem_rdata;
    endcase
  end

  // Result registers: out_valid pulses for one cycle, payload holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid        <= 1'b0;
      r_out_data         <= '0;
      r_out_rd           <= '0;
      r_out_load_regfile <= 1'b0;
      r_out_misalign     <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept && !w_in_mem) begin
        r_out_valid        <= 1'b1;
        r_out_data         <= in_addr;
        r_out_rd           <= in_rd;
        r_out_load_regfile <= in_load_regfile;
        r_out_misalign     <= 1'b0;
      end else if (w_accept && w_in_misalign) begin
        r_out_valid        <= 1'b1;
        r_out_data         <= in_addr;
        r_out_rd           <= in_rd;
        r_out_load_regfile <= 1'b0;
        r_out_misalign     <= 1'b1;
      end else if (w_done) begin
        r_out_valid        <= 1'b1;
        r_out_data         <= r_is_store ? '0 : w_load_data;
        r_out_rd           <= r_rd;
        r_out_load_regfile <= r_is_store ? 1'b0 : r_load_regfile;
        r_out_misalign     <= 1'b0;
      end
    end
  end

  assign out_valid        = r_out_valid;
  assign out_data         = r_out_data;
  assign out_rd           = r_out_rd;
  assign out_load_regfile = r_out_load_regfile;
  assign out_misalign     = r_out_misalign;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases plus randomized
// transactions compared against an arithmetic reference model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = '0;
  logic [31:0] in_wdata = '0;
  logic [2:0]  in_funct3 = '0;
  logic [4:0]  in_rd = '0;
  logic        in_mem_read = 1'b0;
  logic        in_mem_write = 1'b0;
  logic        in_load_regfile = 1'b0;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_resp = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_load_regfile;
  logic        out_misalign;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_stage #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_funct3(in_funct3),
    .in_rd(in_rd), .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .in_load_regfile(in_load_regfile),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_addr(dmem_addr),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .out_valid(out_valid), .out_data(out_data), .out_rd(out_rd),
    .out_load_regfile(out_load_regfile), .out_misalign(out_misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Reference model: access width in bytes from funct3.
  function automatic int nbytes(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  // Byte offset of the access inside the word, rounded down to its size.
  function automatic int lane_off(input logic [31:0] addr, input int nb);
    int off;
    off = int'(addr[1:0]);
    return off - (off % nb);
  endfunction

  function automatic logic [3:0] model_wmask(input logic [31:0] addr, input int nb);
    int m;
    m = ((1 << nb) - 1) << lane_off(addr, nb);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input int nb);
    logic [31:0] lo;
    if (nb == 1) begin lo = wd & 32'hFF;   return lo * 32'h01010101; end
    if (nb == 2) begin lo = wd & 32'hFFFF; return lo * 32'h00010001; end
    return wd;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] addr,
                                             input logic [2:0] f3);
    int nb;
    logic [31:0] v, m, top;
    nb = nbytes(f3);
    v = rdata >> (8 * lane_off(addr, nb));
    if (nb == 4) return v;
    m = (32'd1 << (8 * nb)) - 32'd1;
    top = 32'd1 << (8 * nb - 1);
    v = v & m;
    if (!f3[2] && ((v & top) != 0)) v = v | ~m;
    return v;
  endfunction

  // One transaction starting at a falling edge with the stage idle; ends one
  // cycle after the result pulse so the pulse width is also checked.
  task automatic run_txn(input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3,
                         input logic [4:0] rd, input logic mr, input logic mw, input logic lrf,
                         input int lat, input logic [31:0] rdata);
    int nb;
    logic is_mem, is_store, trap;
    nb = nbytes(f3);
    is_mem = mr | mw;
    is_store = mw;
    trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = is_mem && ((nb == 2 && addr[0]) || (nb == 4 && addr[1:0] != 2'b00));
`endif
    check("idle_ready", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_addr = addr; in_wdata = wdata; in_funct3 = f3; in_rd = rd;
    in_mem_read = mr; in_mem_write = mw; in_load_regfile = lrf;
    dmem_resp = is_mem ? 1'b0 : 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    dmem_resp = 1'b0;
    if (!is_mem || trap) begin
      check("pass_valid", {31'b0, out_valid}, 32'd1);
      check("pass_data", out_data, addr);
      check("pass_rd", {27'b0, out_rd}, {27'b0, rd});
      check("pass_lrf", {31'b0, out_load_regfile}, {31'b0, lrf & ~trap});
      check("pass_misalign", {31'b0, out_misalign}, {31'b0, trap});
      check("pass_no_strobe", {30'b0, dmem_read, dmem_write}, 32'd0);
      check("pass_ready", {31'b0, in_ready}, 32'd1);
    end else begin
      for (int k = 1; k <= lat; k++) begin
        check("acc_ready", {31'b0, in_ready}, 32'd0);
        check("acc_read", {31'b0, dmem_read}, {31'b0, ~is_store});
        check("acc_write", {31'b0, dmem_write}, {31'b0, is_store});
        check("acc_addr", dmem_addr, addr & 32'hFFFF_FFFC);
        check("acc_wmask", {28'b0, dmem_wmask}, is_store ? {28'b0, model_wmask(addr, nb)} : 32'd0);
        if (is_store) check("acc_wdata", dmem_wdata, model_wdata(wdata, nb));
        check("acc_no_out", {31'b0, out_valid}, 32'd0);
        if (k == lat) begin
          dmem_resp = 1'b1;
          dmem_rdata = rdata;
        end
        @(negedge clk);
      end
      dmem_resp = 1'b0;
      check("done_valid", {31'b0, out_valid}, 32'd1);
      check("done_data", out_data, is_store ? 32'd0 : model_load(rdata, addr, f3));
      check("done_rd", {27'b0, out_rd}, {27'b0, rd});
      check("done_lrf", {31'b0, out_load_regfile}, {31'b0, lrf & ~is_store});
      check("done_misalign", {31'b0, out_misalign}, 32'd0);
      check("done_ready", {31'b0, in_ready}, 32'd1);
      check("done_strobes", {30'b0, dmem_read, dmem_write}, 32'd0);
    end
    @(negedge clk);
    check("pulse_end", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [2:0] f3;
    logic mr, mw;
    int kind;

    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, in_ready}, 32'd1);
    check("rst_strobes", {30'b0, dmem_read, dmem_write}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_dmem_addr", dmem_addr, 32'd0);
    check("rst_wmask", {28'b0, dmem_wmask}, 32'd0);
    check("rst_misalign", {31'b0, out_misalign}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases from the known-answer list.
    run_txn(32'h0000_1003, 32'h0000_00A5, 3'b000, 5'd3, 1'b0, 1'b1, 1'b1, 1, 32'h0);
    check("sb_hold_data", out_data, 32'h0);
    run_txn(32'h0000_1002, 32'h0, 3'b000, 5'd4, 1'b1, 1'b0, 1'b1, 1, 32'h12F4_5678);
    check("lb_const", out_data, 32'hFFFF_FFF4);
    run_txn(32'h0000_1002, 32'h0, 3'b100, 5'd4, 1'b1, 1'b0, 1'b1, 1, 32'h12F4_5678);
    check("lbu_const", out_data, 32'h0000_00F4);
    run_txn(32'h0000_1002, 32'h0, 3'b001, 5'd5, 1'b1, 1'b0, 1'b1, 2, 32'h8001_ABCD);
    check("lh_const", out_data, 32'hFFFF_8001);
    run_txn(32'h0000_1004, 32'h0, 3'b010, 5'd6, 1'b1, 1'b0, 1'b1, 4, 32'hDEAD_BEEF);
    check("lw_slow_const", out_data, 32'hDEAD_BEEF);
    check("lw_hold_rd", {27'b0, out_rd}, 32'd6);

    // Back-to-back non-memory ops.
    in_valid = 1'b1; in_mem_read = 1'b0; in_mem_write = 1'b0; in_load_regfile = 1'b1;
    in_addr = 32'h55; in_rd = 5'd7;
    @(negedge clk);
    in_addr = 32'h66; in_rd = 5'd8;
    check("b2b_v0", {31'b0, out_valid}, 32'd1);
    check("b2b_d0", out_data, 32'h55);
    check("b2b_r0", {27'b0, out_rd}, 32'd7);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_v1", {31'b0, out_valid}, 32'd1);
    check("b2b_d1", out_data, 32'h66);
    check("b2b_r1", {27'b0, out_rd}, 32'd8);
    @(negedge clk);
    check("b2b_end", {31'b0, out_valid}, 32'd0);

    // Reset in the middle of an access, then a late response.
    in_valid = 1'b1; in_addr = 32'h0000_2000; in_funct3 = 3'b010;
    in_mem_read = 1'b1; in_mem_write = 1'b0; in_rd = 5'd9;
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_mid_read", {31'b0, dmem_read}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_strobe", {30'b0, dmem_read, dmem_write}, 32'd0);
    check("rst_mid_ready", {31'b0, in_ready}, 32'd1);
    #1;
    rst = 1'b0;
    dmem_resp = 1'b1;
    dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    dmem_resp = 1'b0;
    check("rst_late_resp", {31'b0, out_valid}, 32'd0);
    check("rst_late_ready", {31'b0, in_ready}, 32'd1);
    in_mem_read = 1'b0;

`ifdef MEM_MISALIGN_TRAP_EN
    run_txn(32'h0000_1002, 32'h0, 3'b010, 5'd10, 1'b1, 1'b0, 1'b1, 1, 32'h0);
    check("trap_flag_hold", {31'b0, out_misalign}, 32'd1);
`endif

    // Randomized transactions.
    for (int t = 0; t < 200; t++) begin
      kind = int'($urandom_range(0, 3));
      mr = (kind == 1) || (kind == 3);
      mw = (kind == 2) || (kind == 3);
      f3 = mw ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      run_txn($urandom, $urandom, f3, 5'($urandom), mr, mw, 1'($urandom_range(0, 1)),
              int'($urandom_range(1, 4)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
Pipeline stage downstream of execute. Consumes the registered execute result (ALU address/result, store data, funct3, rd, control) and performs RV32I load/store through a req/resp data-memory handshake, stalling upstream until the memory responds. Produces the aligned writeback value and destination for the writeback stage.

Parameters:
WIDTH, 32, data/address width; only 32 is supported.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream stage holds a valid instruction
in_ready  output  1  stage can accept; low means upstream must hold its values
in_addr  input  32  ALU result; memory address for load/store, writeback value otherwise
in_wdata  input  32  store data (rs2 value)
in_funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
in_rd  input  5  destination register
in_mem_read  input  1  instruction is a load
in_mem_write  input  1  instruction is a store
in_load_regfile  input  1  instruction writes rd
dmem_read  output  1  read request strobe, held until dmem_resp
dmem_write  output  1  write request strobe, held until dmem_resp
dmem_addr  output  32  word-aligned address {addr[31:2],2'b00}
dmem_wmask  output  4  byte enables for stores
dmem_wdata  output  32  lane-replicated store data
dmem_rdata  input  32  read data, valid while dmem_resp=1
dmem_resp  input  1  single-cycle completion of the current request
out_valid  output  1  one-cycle pulse: result registers valid
out_data  output  32  aligned/extended load data, or in_addr for non-memory ops
out_rd  output  5  destination register
out_load_regfile  output  1  writeback enable
out_misalign  output  1  misaligned-access flag (see Optional Feature)

Behaviour:
- FSM states IDLE, ACCESS. Reset: state IDLE; all outputs 0 except in_ready=1 (combinational from state).
- in_ready = (state==IDLE). Accepted transfer = in_valid && in_ready at a rising edge.
- Non-memory accept (neither mem_read nor mem_write): next cycle out_valid=1, out_data=in_addr, out_rd/out_load_regfile copied. Latency 1; back-to-back every cycle.
- Memory accept: request (addr, wdata, funct3, rd, ctrl) captured into internal registers; state→ACCESS. dmem_read/dmem_write/addr/wmask/wdata are driven from those registers only, stable for the whole ACCESS period.
- ACCESS: on the edge where dmem_resp=1: out_valid=1 next cycle with aligned data (stores: out_data=0, out_load_regfile=0), state→IDLE. Minimum memory latency 2 cycles (resp in first ACCESS cycle).
- out_valid deasserts after one cycle unless a new result completes; out_data/out_rd hold last value.
- Store alignment, o=addr[1:0]: SB wmask=4'b0001<<o, wdata={4{wdata[7:0]}}; SH wmask=4'b0011<<{o[1],1'b0}, wdata={2{wdata[15:0]}}; SW wmask=4'b1111, wdata unchanged. Loads drive wmask=0.
- Load extraction: byte at lane o, half at lane o[1]; B/H sign-extend, BU/HU zero-extend, W unmodified.
- Undefined funct3 (011,110,111) treated as W.
- dmem_resp in IDLE is ignored. mem_read and mem_write both high: treated as store.
- Reset asserted mid-ACCESS: request abandoned, strobes drop immediately (async), no out_valid; a late dmem_resp after reset is ignored.

Optional Feature:
MEM_MISALIGN_TRAP_EN. Defined: H with addr[0]=1 or W with addr[1:0]!=0 is not issued; next cycle out_valid=1, out_misalign=1, out_load_regfile=0, out_data=in_addr, state stays IDLE. Undefined: out_misalign tied 0; misaligned H uses addr[1] lane, misaligned W forced aligned, access issued normally.

Test Plan:
SB addr 0x00001003 wdata 0x000000A5, resp 1st ACCESS cycle -> dmem_write=1, dmem_addr 0x00001000, wmask 4'b1000, wdata 0xA5A5A5A5; out_valid 2 cycles after accept, out_load_regfile=0.
LB addr 0x00001002, rdata 0x12F45678 -> out_data 0xFFFFFFF4; same with LBU -> 0x000000F4.
LH addr 0x00001002, rdata 0x8001ABCD -> out_data 0xFFFF8001; LW addr 0x00001004 -> out_data = rdata.
LW with dmem_resp delayed 3 cycles -> in_ready low 4 cycles, dmem_read/addr stable throughout, single out_valid pulse.
Non-memory ops in_addr 0x55 rd 7 then 0x66 rd 8 on consecutive cycles -> out_valid two consecutive cycles, out_data 0x55 then 0x66.
rst pulsed during ACCESS, then dmem_resp=1 -> strobes 0 immediately, no out_valid, in_ready=1; with macro, LW at 0x00001002 -> no dmem strobe, out_misalign=1.
